// File: rtl/clk_div_prog_if.sv
// Control and status bundle for the programmable clock divider.
//   en_i   : count enable (master -> divider)
//   load_i : one-cycle request to capture div_i as the pending divisor
//   div_i  : requested divisor
//   clk_o  : divided clock (divider -> master)
//   tick_o : one-cycle strobe per divided period
//   ack_o  : one-cycle pulse when a pending divisor becomes active
//   div_o  : currently active divisor
interface clk_div_prog_if #(
    parameter int WIDTH = 16
);
    logic             en_i;
    logic             load_i;
    logic [WIDTH-1:0] div_i;
    logic             clk_o;
    logic             tick_o;
    logic             ack_o;
    logic [WIDTH-1:0] div_o;

    modport master (
        output en_i, load_i, div_i,
        input  clk_o, tick_o, ack_o, div_o
    );

    modport slave (
        input  en_i, load_i, div_i,
        output clk_o, tick_o, ack_o, div_o
    );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider.
// Divides clk_i by D >= 2. clk_o is low for D>>1 cycles and high for the
// rest of each period; tick_o strobes once per period, in the cycle where
// clk_o falls. A loaded divisor is held pending and only becomes active at
// a period boundary, so a change never produces a runt pulse.
// Ports:
//   clk_i  : system clock
//   rst_ni : synchronous active-low reset
//   bus    : control/status bundle (slave side), see clk_div_prog_if
module clk_div_prog #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    clk_div_prog_if.slave  bus
);
    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

    // Divisors below 2 cannot form a period with both phases; force to 2.
    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
        if (d < MIN_DIV) begin
            clamp_div = MIN_DIV;
        end else begin
            clamp_div = d;
        end
    endfunction

    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] pend_r;
    logic             pend_valid_r;
    logic             clk_r;
    logic             tick_r;
    logic             ack_r;

    logic [WIDTH-1:0] half_s;
    logic             wrap_s;
    logic [WIDTH-1:0] cnt_next_s;

    // Low-phase length, wrap detection and next counter value for the active divisor.
    always_comb begin
        half_s     = {1'b0, div_r[WIDTH-1:1]};
        wrap_s     = (cnt_r == (div_r - WIDTH'(1)));
        cnt_next_s = cnt_r;
        if (wrap_s) begin
            cnt_next_s = {WIDTH{1'b0}};
        end else begin
            cnt_next_s = cnt_r + WIDTH'(1);
        end
    end

    // Counter, output registers and pending/active divisor bookkeeping.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_r        <= {WIDTH{1'b0}};
            div_r        <= DEF_DIV;
            pend_r       <= {WIDTH{1'b0}};
            pend_valid_r <= 1'b0;
            clk_r        <= 1'b0;
            tick_r       <= 1'b0;
            ack_r        <= 1'b0;
        end else begin
            if (bus.en_i) begin
                cnt_r  <= cnt_next_s;
                clk_r  <= (cnt_next_s >= half_s);
                // cnt_next is zero only on the wrap, so the wrap alone marks the tick.
                tick_r <= wrap_s;
                // Only a divisor pending before this edge may switch here.
                if (wrap_s && pend_valid_r) begin
                    div_r        <= pend_r;
                    pend_valid_r <= 1'b0;
                    ack_r        <= 1'b1;
                end else begin
                    ack_r <= 1'b0;
                end
            end else begin
                tick_r <= 1'b0;
                ack_r  <= 1'b0;
            end
            // Placed last so a capture on the switching edge re-arms pending.
            if (bus.load_i) begin
                pend_r       <= clamp_div(bus.div_i);
                pend_valid_r <= 1'b1;
            end else begin
                pend_r       <= pend_r;
            end
        end
    end

    assign bus.clk_o  = clk_r;
    assign bus.tick_o = tick_r;
    assign bus.ack_o  = ack_r;
    assign bus.div_o  = div_r;
endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Parametrised, runtime-programmable integer clock divider; successor to the fixed divide-by-2 toggle divider.
- Divides clk_i by an integer D >= 2, with these outputs:
  - clk_o: a square-like divided clock.
  - tick_o: a one-cycle strobe, for use as a clock enable.
- D can be changed at runtime without glitches. A new divisor takes effect only at a period boundary.
- Sits in the clocking/timebase area and feeds slower downstream logic (display scan, baud and sample timers).

Parameters:
- WIDTH, 16, width of the divisor and of the internal counter.
- DEFAULT_DIV, 2, divisor active after reset. Must be in the range 2..2^WIDTH-1. Default 2 reproduces the plain toggle divider.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  reset; synchronous, active-low.
- en_i  input  1  count enable; when low, the divider freezes.
- load_i  input  1  one-cycle request to capture div_i as the pending divisor.
- div_i  input  WIDTH  requested divisor.
- clk_o  output  1  divided clock, registered.
- tick_o  output  1  one-cycle strobe, asserted once per divided period.
- ack_o  output  1  one-cycle pulse on the cycle a pending divisor becomes active.
- div_o  output  WIDTH  currently active divisor.

Behaviour:
- Reset, sampled on the clk_i rising edge while rst_ni=0:
  - cnt=0, active D=DEFAULT_DIV, pending_valid=0, pending=0.
  - clk_o=0, tick_o=0, ack_o=0, div_o=DEFAULT_DIV.
  - Reset overrides all other inputs in the same cycle.
- Phase split: L = D>>1 (low-phase length), H = D-L (high-phase length). For odd D the high phase is one cycle longer.
- Counter: on each edge with en_i=1, cnt_next = (cnt==D-1) ? 0 : cnt+1. The wrap is the transition cnt D-1 -> 0.
- Output registers, driven from cnt_next:
  - clk_o <= (cnt_next >= L).
  - tick_o <= en_i & (cnt_next==0) & (cnt==D-1). This is high exactly in the cycle after the wrap edge, coincident with clk_o going low.
- Timing with D=2: clk_o toggles every clk_i edge, starting at 0 and going 1 on the first enabled edge. This is identical to the plain toggle divider.
- en_i=0: cnt and clk_o hold, tick_o=0, ack_o=0. Divisor loads are still captured.
- Loading a divisor:
  - load_i=1 captures div_i into pending and sets pending_valid=1.
  - div_i of 0 or 1 is clamped to 2 on capture.
  - A later load_i before the switch overwrites pending; last write wins.
- Switching the divisor:
  - At a wrap edge with pending_valid=1, D <= pending, pending_valid <= 0, and ack_o pulses one cycle, aligned with tick_o.
  - The new D governs cnt_next and the L/H compare from the next edge onward. The period that just ended used the old D in full.
- load_i on the wrap edge itself: the capture happens on that edge, but the divisor is not applied at that wrap. It is applied at the following wrap. The switch at the wrap uses only a pending_valid that was already set before that edge.
- div_o always equals active D and changes in the same cycle ack_o is high.
- No mid-period truncation. A divisor change never shortens or extends the period in progress, so there are no runt pulses on clk_o.
- Reset mid-period: the period is abandoned, outputs return to reset values next cycle, and any pending divisor is discarded.
- Counter compares are unsigned, WIDTH bits. cnt never exceeds D-1.

Test Plan:
- Reset then en_i=1, default D=2, 8 edges -> clk_o 1,0,1,0,1,0,1,0; tick_o high on edges 2,4,6,8; div_o=2.
- load_i with div_i=5 while en_i=1 -> no change until the current period ends; then ack_o=1 together with tick_o and div_o=5. Each subsequent period: clk_o low 2 cycles, high 3; tick_o every 5 cycles.
- div_i=4, then div_i=7 loaded on two consecutive non-wrap cycles -> one ack_o at the next wrap; div_o=7; period 7, low 3 / high 4.
- load_i asserted exactly on the wrap edge with div_i=3 -> no ack at that wrap; ack_o and the switch to D=3 occur at the following wrap.
- en_i=0 for 10 cycles mid-period at D=6 -> clk_o and cnt frozen, tick_o=0; on resume the remaining cycles of the period complete, so the period is 6 enabled cycles. div_i=0 or 1 loaded -> div_o=2 after the next wrap.
- rst_ni=0 for 1 cycle mid-period at D=9 with a pending load -> clk_o=0, tick_o=0, div_o=DEFAULT_DIV, pending discarded, no ack afterwards.
